// File: rtl/led_pkg.sv
// Shared types and helpers for the LED sharing arbiter.
package led_pkg;

    localparam int REQ_MAX = 8;

    typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_e;

    // Pin level pattern for an all-dark bank, in the low n bits.
    function automatic logic [31:0] led_off(input logic mode, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (i < n) r[i] = ~mode;
        return r;
    endfunction

    // Clock cycles per millisecond (truncated).
    function automatic int ms_tick_div(input int clk_freq);
        return clk_freq / 1000;
    endfunction

    // One-hot of the first set bit searching upward from ptr with wrap.
    // Bits above the real requester count are zero, so wrapping over
    // REQ_MAX gives the same answer as wrapping over REQ_NUM.
    function automatic logic [REQ_MAX-1:0] rr_pick(input logic [REQ_MAX-1:0] req,
                                                   input logic [2:0]         ptr);
        logic [2:0]         idx;
        logic [REQ_MAX-1:0] r;
        r = '0;
        for (int i = REQ_MAX - 1; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (req[idx]) begin
                r      = '0;
                r[idx] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/led_ms_tick.sv
// Clearable millisecond prescaler: 1-cycle pulse when the count reaches TICK-1.
module led_ms_tick #(
    parameter int TICK = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK > 1) ? $clog2(TICK) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(TICK - 1));

    // Next count: clear on request, wrap on tick, else increment.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || tick_o) cnt_d = '0;
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_share_arb.sv
// Round-robin LED bank arbiter with minimum display time and pin polarity.
module led_share_arb
    import led_pkg::*;
#(
    parameter int   LED_NUM     = 5,
    parameter int   REQ_NUM     = 4,
    parameter logic LED_ON_MODE = 1'b0,
    parameter int   CLK_FREQ    = 50_000_000,
    parameter int   HOLD_MS     = 500
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic [REQ_NUM-1:0]         req_i,
    input  logic [REQ_NUM*LED_NUM-1:0] pat_i,
    output logic [REQ_NUM-1:0]         gnt_o,
    output logic [LED_NUM-1:0]         led_o,
    output logic                       busy_o
);

    localparam int TICK = ms_tick_div(CLK_FREQ);
    localparam int PW   = $clog2(REQ_NUM);
    localparam int HW   = $clog2(HOLD_MS + 1);
    localparam logic [LED_NUM-1:0] OFF = LED_NUM'(led_off(LED_ON_MODE, LED_NUM));

    state_e             state_q, state_d;
    logic [REQ_NUM-1:0] gnt_q, gnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [LED_NUM-1:0] led_q, led_d;
    logic [LED_NUM-1:0] sel_pat;
    logic [REQ_NUM-1:0] others;
    logic               tick;
    logic               tick_clr;

    // Prescaler only runs while a grant stays in its hold window.
    assign tick_clr = !(state_q == HOLD && state_d == HOLD);

    led_ms_tick #(.TICK(TICK)) u_ms_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    assign others = req_i & ~gnt_q;

    // Arbitration FSM next state, grant, pointer and displayed pattern.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        led_d   = led_q;
        sel_pat = '0;
        if (!en_i) begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: if (|req_i) begin
                    gnt_d   = REQ_NUM'(rr_pick(REQ_MAX'(req_i), 3'(ptr_q)));
                    hold_d  = '0;
                    state_d = HOLD;
                end
                HOLD: if (tick) begin
                    if (hold_q == HW'(HOLD_MS - 1)) state_d = OPEN;
                    if (hold_q != HW'(HOLD_MS))     hold_d  = hold_q + HW'(1);
                end
                OPEN: begin
                    if (|others) begin
                        // ptr_q already points just past the current owner
                        gnt_d   = REQ_NUM'(rr_pick(REQ_MAX'(others), 3'(ptr_q)));
                        hold_d  = '0;
                        state_d = HOLD;
                    end else if (!(|(req_i & gnt_q))) begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            endcase
        end
        // New owner k moves the pointer to k+1
        if (|gnt_d && gnt_d != gnt_q)
            for (int k = 0; k < REQ_NUM; k++)
                if (gnt_d[k]) ptr_d = PW'((k + 1) % REQ_NUM);
        for (int k = 0; k < REQ_NUM; k++)
            if (gnt_d[k]) sel_pat = pat_i[k*LED_NUM +: LED_NUM];
        // Track the owner's pattern while it requests, freeze it otherwise
        if (!(|gnt_d))              led_d = OFF;
        else if (|(gnt_d & req_i))  led_d = LED_ON_MODE ? sel_pat : ~sel_pat;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            led_q   <= OFF;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            led_q   <= led_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign led_o  = led_q;
    assign busy_o = |gnt_q;

endmodule

// File: doc/led_share_arb.md
# led_share_arb

Arbiter that shares one LED bank among `REQ_NUM` requesters (status, fault and flow-pattern sources), each presenting a pattern. It grants the bank round-robin with a guaranteed minimum display time, so short events stay visible. It applies the board's LED on-polarity. It sits between the pattern generators (e.g. the flow-LED engine) and the LED pins.

## Interface
- `LED_NUM`, 5: LED count.
- `REQ_NUM`, 4: requester count, 2..8.
- `LED_ON_MODE`, 1'b0: pin level that lights an LED.
- `CLK_FREQ`, 50_000_000: clock in Hz. `TICK = CLK_FREQ/1000` (truncated), must be ≥1.
- `HOLD_MS`, 500: minimum grant time in ms, ≥1.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `en_i` in 1: global enable.
- `req_i` in `REQ_NUM`: request bit per requester.
- `pat_i` in `REQ_NUM*LED_NUM`: logical patterns (1 = lit). Requester k uses `[k*LED_NUM +: LED_NUM]`.
- `gnt_o` out `REQ_NUM`: one-hot grant, registered.
- `led_o` out `LED_NUM`: pin drive, registered.
- `busy_o` out 1: high while any grant is active.

## Operation
- `OFF` = `{LED_NUM{~LED_ON_MODE}}`. Pin drive is `led_o = LED_ON_MODE ? pat : ~pat`.
- Reset values: `gnt_o = 0`, `led_o = OFF`, `busy_o = 0`, state IDLE, RR pointer = 0, counters = 0.
- FSM states:
  - **IDLE**: if `en_i` is high and `req_i` ≠ 0, grant the first requesting index searching from the pointer upward with wrap. Go to HOLD.
  - **HOLD**: display the granted pattern. The ms prescaler and hold counter run. After `HOLD_MS*TICK` cycles, go to OPEN.
  - **OPEN**: evaluated every cycle.
    - Another requester is pending: switch the grant to the next requester after the current one (RR order). Go to HOLD; counters clear.
    - Only the current requester is pending: keep the grant and stay in OPEN.
    - No requests: go to IDLE, `gnt_o = 0`, `led_o = OFF`.
- Grant to index k sets the pointer to k+1 mod `REQ_NUM`.
- Displayed pattern:
  - `pat_i` of the granted requester is sampled every cycle while its `req_i` is high.
  - If that `req_i` drops during HOLD, the last sampled pattern is frozen. The grant stays until the hold expires.
- `en_i` low in any state:
  - Next edge: IDLE, `gnt_o = 0`, `led_o = OFF`, counters cleared.
  - The RR pointer is retained.
  - This has priority over all other transitions.
- `busy_o = |gnt_o`.

## Timing
- Grant latency: request seen in IDLE at edge n → `gnt_o` and `led_o` valid after edge n+1.
- Pattern tracking: `led_o` follows `pat_i` of the granted requester with 1 cycle latency.
- Hold: grant asserted at edge E → OPEN entered at edge `E + HOLD_MS*TICK`.
  - An earliest switch or release takes effect at edge `E + HOLD_MS*TICK + 1`.
  - A grant therefore lasts at least `HOLD_MS*TICK + 1` cycles.
- Counter widths:
  - Prescaler: `$clog2(TICK)`, cleared at every grant change. Its tick fires at count `TICK-1`.
  - Hold counter: `$clog2(HOLD_MS+1)`, saturating.
- Reset mid-grant: all outputs return to reset values at that edge, and the pointer returns to 0.
- Simultaneous new requests in IDLE: RR order from the pointer decides; the lowest index wins after reset.

## Structure
- Package `led_pkg`:
  - state enum `{IDLE, HOLD, OPEN}`.
  - function `led_off(LED_ON_MODE, LED_NUM)`.
  - function `ms_tick_div(CLK_FREQ)`.
  - function `rr_pick(req, ptr)`, returning one-hot.
- One sub-module, `led_ms_tick`: clearable prescaler that emits a 1-cycle pulse every `TICK` cycles.
- The FSM, pattern register and polarity stage stay in `led_share_arb`.

## Test plan
All scenarios use `LED_NUM=5`, `REQ_NUM=4`, `CLK_FREQ=10_000` (TICK=10), `HOLD_MS=3`, `LED_ON_MODE=0`.
- **Reset:** hold `rst_n=0` for 3 cycles → `led_o=5'b11111`, `gnt_o=0`, `busy_o=0`. After release, with no requests, outputs stay unchanged.
- **Single grant:** `req_i=4'b0010`, pattern 1 = `5'b00101` at edge n → at n+1, `gnt_o=4'b0010`, `led_o=5'b11010`, `busy_o=1`. Changing pattern 1 to `5'b10000` → `led_o=5'b01111` one cycle later.
- **Hold then switch:** requester 1 granted at E; requester 0 asserts at E+5 → `gnt_o` stays `0010` through E+30, becomes `0001` at E+31.
- **Round-robin:** from reset, `req_i=4'b1111` held → grant order 0,1,2,3,0, each grant exactly 31 cycles apart.
- **Early drop:** requester 2 is granted at E with pattern `5'b00011` and drops its request at E+4 while `pat_i` changes → `led_o` stays `5'b11100` until E+30. At E+31, `gnt_o=0`, `led_o=5'b11111`.
- **Disable:** `en_i=0` at E+10 of a grant to requester 3 → next edge `gnt_o=0`, `led_o=5'b11111`. Re-enable with `req_i=4'b1001` → requester 0 is granted, because the retained pointer is 0 after the grant to requester 3.
